sr_flag_arbiter: RTL and testbench

Shared SR-flag bank with a round-robin front end. Up to NREQ requesters issue set or clear commands against one of NFLAG single-bit SR flags. The arbiter grants one command at a time, so a flag never receives S=1 and R=1 together. The block sits between control FSMs and the status-flag storage, and replaces per-requester SR flip-flops that would otherwise share nets.

---
 rtl/sr_flag_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/sr_flag_arbiter.sv | 99 +++++++++
 tb/tb_sr_flag_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sr_flag_pkg.sv
// rtl/sr_flag_pkg.sv - shared types, constants and helpers for the SR-flag arbiter
package sr_flag_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  // Width of a flag index for a bank of n flags.
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] win_id,
  output logic                    valid
);

  localparam int PW = $clog2(NREQ);

  // Scan requesters from ptr upward, wrapping, and take the first one asserted.
  always_comb begin
    int  cand;
    logic found;
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        win[cand] = 1'b1;
        win_id    = PW'(cand);
      end
    end
    valid = found;
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - SR flag bank written one command at a time via round-robin grant
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ-1:0]                op,
  input  logic [NREQ*idx_w(NFLAG)-1:0]   idx,
  input  logic                           clr_all,
  output logic [NREQ-1:0]                gnt,
  output logic [NFLAG-1:0]               q,
  output logic [NFLAG-1:0]               q_bar,
  output logic                           busy
);

  localparam int IW = idx_w(NFLAG);
  localparam int PW = $clog2(NREQ);

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [NFLAG-1:0]  q_nxt;

  logic [NREQ-1:0]   win;
  logic [PW-1:0]     win_id;
  logic              win_valid;
  logic [IW-1:0]     idx_arr [NREQ];
  logic [IW-1:0]     idx_sel;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req    (req),
    .ptr    (ptr),
    .win    (win),
    .win_id (win_id),
    .valid  (win_valid)
  );

  // Unpack the per-requester index slices so the winner's index can be selected.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      idx_arr[i] = idx[i*IW +: IW];
    end
  end

  assign idx_sel = idx_arr[win_id];

  // Next-state, grant and flag-write decode; only IDLE arbitrates, clr_all always wins over writes.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    q_nxt     = q;
    case (state)
      IDLE: begin
        if (clr_all) begin
          q_nxt = '0;
        end else if (win_valid) begin
          state_nxt = GRANT;
          gnt_nxt   = win;
          ptr_nxt   = (int'(win_id) == NREQ - 1) ? '0 : win_id + PW'(1);
          // Out-of-range index still consumes a grant but writes nothing.
          if (int'(idx_sel) < NFLAG) begin
            q_nxt[idx_sel] = (op[win_id] == OP_SET) ? OP_SET : OP_CLR;
          end
        end
      end
      GRANT: begin
        state_nxt = IDLE;
        if (clr_all) begin
          q_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, grant and flag registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      q     <= q_nxt;
    end
  end

  assign q_bar = ~q;
  assign busy  = (state == GRANT);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - directed self-checking bench for sr_flag_arbiter
module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   op;
  logic [NREQ*IW-1:0] idx;
  logic              clr_all;
  logic [NREQ-1:0]   gnt;
  logic [NFLAG-1:0]  q;
  logic [NFLAG-1:0]  q_bar;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op      (op),
    .idx     (idx),
    .clr_all (clr_all),
    .gnt     (gnt),
    .q       (q),
    .q_bar   (q_bar),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic o, input logic [IW-1:0] f);
    op[r] = o;
    idx[r*IW +: IW] = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; idx = '0; clr_all = 1'b0;

    // 1. reset
    tick(); tick();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_qbar", 32'(q_bar), 32'hFF);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // 2. single set then clear
    set_cmd(1, 1'b1, 3'd5); req = 4'b0010;
    tick();
    chk("set_gnt", 32'(gnt), 32'h2);
    chk("set_q", 32'(q), 32'h20);
    chk("set_busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    chk("set_idle_gnt", 32'(gnt), 32'h0);
    chk("set_idle_busy", 32'(busy), 32'h0);
    set_cmd(1, 1'b0, 3'd5); req = 4'b0010;
    tick();
    chk("clr_gnt", 32'(gnt), 32'h2);
    chk("clr_q", 32'(q), 32'h00);
    req = '0;
    tick();

    // 3. round robin, all requesting
    do_reset();
    for (int r = 0; r < NREQ; r++) set_cmd(r, 1'b1, IW'(r));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("rr_gnt%0d", n), 32'(gnt), 32'(1 << (n % 4)));
      chk($sformatf("rr_q%0d", n), 32'(q), (n < 4) ? 32'((1 << (n + 1)) - 1) : 32'h0F);
      tick();
      chk($sformatf("rr_gap%0d", n), 32'(gnt), 32'h0);
    end
    req = '0;
    tick();

    // 4. same-flag conflict
    do_reset();
    set_cmd(0, 1'b1, 3'd2); set_cmd(1, 1'b0, 3'd2);
    req = 4'b0011;
    tick();
    chk("cf_gnt0", 32'(gnt), 32'h1);
    chk("cf_q2_set", 32'(q[2]), 32'h1);
    chk("cf_excl_a", 32'(q[2] & q_bar[2]), 32'h0);
    req = 4'b0010;
    tick();
    chk("cf_excl_b", 32'(q[2] & q_bar[2]), 32'h0);
    tick();
    chk("cf_gnt1", 32'(gnt), 32'h2);
    chk("cf_q2_clr", 32'(q[2]), 32'h0);
    chk("cf_excl_c", 32'(q[2] & q_bar[2]), 32'h0);
    req = '0;
    tick();

    // 5. clr_all in IDLE with req[3] pending
    do_reset();
    for (int f = 0; f < NFLAG; f++) begin
      set_cmd(0, 1'b1, IW'(f)); req = 4'b0001;
      tick();
      req = '0;
      tick();
    end
    chk("fill_q", 32'(q), 32'hFF);
    set_cmd(3, 1'b1, 3'd3); req = 4'b1000; clr_all = 1'b1;
    tick();
    chk("ca_q", 32'(q), 32'h00);
    chk("ca_gnt", 32'(gnt), 32'h0);
    chk("ca_busy", 32'(busy), 32'h0);
    clr_all = 1'b0;
    tick();
    chk("ca_gnt3", 32'(gnt), 32'h8);
    chk("ca_q3", 32'(q), 32'h08);
    req = '0;
    tick();

    // clr_all during GRANT overwrites the landed write
    set_cmd(0, 1'b1, 3'd7); req = 4'b0001;
    tick();
    chk("cg_gnt", 32'(gnt), 32'h1);
    chk("cg_q_before", 32'(q), 32'h88);
    req = '0; clr_all = 1'b1;
    tick();
    chk("cg_q_after", 32'(q), 32'h00);
    clr_all = 1'b0;

    // 6. reset during GRANT; ptr would otherwise favour requester 3
    set_cmd(2, 1'b1, 3'd6); req = 4'b0100;
    tick();
    chk("mr_gnt2", 32'(gnt), 32'h4);
    chk("mr_q_pre", 32'(q), 32'h40);
    rst = 1'b1; req = 4'b1001;
    tick();
    chk("mr_q", 32'(q), 32'h00);
    chk("mr_gnt", 32'(gnt), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    set_cmd(0, 1'b1, 3'd1); set_cmd(3, 1'b1, 3'd4);
    tick();
    chk("mr_next_gnt", 32'(gnt), 32'h1);
    chk("mr_next_q", 32'(q), 32'h02);
    req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
